// File: rtl/dma_priority_arbiter.sv
// DMA channel request resolver: synchronises DREQ, merges software requests, applies mask and
// fixed/rotating priority, runs the HRQ/HLDA hold handshake and drives DACK for the winning channel.
module dma_priority_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] dreq,
  input  logic              dreq_sense_low,
  input  logic              dack_sense_high,
  input  logic              rotating_pri,
  input  logic              ctrl_disable,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] sw_req,
  input  logic              hlda,
  input  logic              xfer_done,
  output logic              hrq,
  output logic [NUM_CH-1:0] dack,
  output logic              grant_valid,
  output logic [1:0]        grant_ch,
  output logic              svc_start,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    SERVICE   = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] ack, ack_d;
  logic [1:0]        pri_ptr, ptr_d;
  logic [1:0]        base, cand, win_ch;
  logic              win_any;
  logic              hrq_d, gv_d, svc_d;
  logic [1:0]        gc_d;

  // Polarity is corrected before the first flop so every stage holds active-high requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= dreq ^ {NUM_CH{dreq_sense_low}};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pend = (sync_q[SYNC_STAGES-1] & ~mask) | sw_req;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    base    = rotating_pri ? pri_ptr : 2'd0;
    cand    = 2'd0;
    win_ch  = 2'd0;
    win_any = |pend;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = base + 2'(i);
      if (pend[cand]) win_ch = cand;
    end
  end

  // Handshake: hrq is a level request held from IDLE exit until service ends or the request
  // withdraws; hlda is the CPU's level acknowledge, and dropping it ends service immediately.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (!ctrl_disable && win_any) state_d = HOLD_WAIT;
      HOLD_WAIT: begin
        if (!pend[grant_ch]) state_d = IDLE;
        else if (hlda)       state_d = SERVICE;
      end
      SERVICE:   if (xfer_done || !hlda) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    hrq_d = hrq;
    gv_d  = grant_valid;
    gc_d  = grant_ch;
    svc_d = 1'b0;
    ack_d = ack;
    ptr_d = rotating_pri ? pri_ptr : 2'd0;
    case (state)
      IDLE: begin
        if (state_d == HOLD_WAIT) begin
          gc_d  = win_ch;
          hrq_d = 1'b1;
        end
      end
      HOLD_WAIT: begin
        if (!pend[grant_ch]) begin
          hrq_d = 1'b0;
        end else if (hlda) begin
          ack_d = NUM_CH'(1) << grant_ch;
          gv_d  = 1'b1;
          svc_d = 1'b1;
        end
      end
      SERVICE: begin
        if (xfer_done || !hlda) begin
          ack_d = '0;
          gv_d  = 1'b0;
          hrq_d = 1'b0;
          // Only a completed service rotates; an hlda abort keeps the pointer.
          if (xfer_done && rotating_pri) ptr_d = grant_ch + 2'd1;
        end
      end
      default: begin
        ack_d = '0;
        gv_d  = 1'b0;
        hrq_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hrq         <= 1'b0;
      grant_valid <= 1'b0;
      grant_ch    <= 2'd0;
      svc_start   <= 1'b0;
      ack         <= '0;
      pri_ptr     <= 2'd0;
    end else begin
      state       <= state_d;
      hrq         <= hrq_d;
      grant_valid <= gv_d;
      grant_ch    <= gc_d;
      svc_start   <= svc_d;
      ack         <= ack_d;
      pri_ptr     <= ptr_d;
    end
  end

  assign dack      = ack ^ {NUM_CH{~dack_sense_high}};
  assign fsm_state = state;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: a per-cycle vector table plus hand sequences for
// rotation, aborted service and asynchronous reset.
`timescale 1ns/1ps
module tb_dma_priority_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] dreq = '0, mask = '0, sw_req = '0;
  logic       dreq_sense_low = 1'b0, dack_sense_high = 1'b0;
  logic       rotating_pri = 1'b0, ctrl_disable = 1'b0;
  logic       hlda = 1'b0, xfer_done = 1'b0;
  logic       hrq, grant_valid, svc_start;
  logic [3:0] dack;
  logic [1:0] grant_ch, fsm_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] dreq, mask, sw_req;
    logic       hlda, xfer_done, dsl, dsh, dis;
    logic       e_hrq, e_gv;
    logic [1:0] e_gc;
    logic       e_svc;
    logic [3:0] e_dack;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];

  dma_priority_arbiter #(.NUM_CH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .dreq(dreq), .dreq_sense_low(dreq_sense_low),
    .dack_sense_high(dack_sense_high), .rotating_pri(rotating_pri), .ctrl_disable(ctrl_disable),
    .mask(mask), .sw_req(sw_req), .hlda(hlda), .xfer_done(xfer_done), .hrq(hrq), .dack(dack),
    .grant_valid(grant_valid), .grant_ch(grant_ch), .svc_start(svc_start), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] d, input logic [3:0] m, input logic [3:0] s,
                     input logic hl, input logic xd, input logic dsl, input logic dsh,
                     input logic dis, input logic eh, input logic egv, input logic [1:0] egc,
                     input logic esvc, input logic [3:0] edk);
    vec_t v;
    v.dreq = d; v.mask = m; v.sw_req = s; v.hlda = hl; v.xfer_done = xd;
    v.dsl = dsl; v.dsh = dsh; v.dis = dis;
    v.e_hrq = eh; v.e_gv = egv; v.e_gc = egc; v.e_svc = esvc; v.e_dack = edk;
    vecs.push_back(v);
  endtask

  task automatic do_service(input logic [1:0] ch);
    logic [3:0] e_dk;
    e_dk = 4'b1111;
    e_dk[ch] = 1'b0;
    chk("rot_hrq", {3'b0, hrq}, 4'd1);
    chk("rot_gc", {2'b0, grant_ch}, {2'b0, ch});
    hlda = 1'b1;
    tick();
    chk("rot_gv", {3'b0, grant_valid}, 4'd1);
    chk("rot_dack", dack, e_dk);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    hlda = 1'b0;
    chk("rot_gap_hrq", {3'b0, hrq}, 4'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Each row: inputs applied, one clock edge, outputs compared.
    add(4'hA,4'h0,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'hA,4'h0,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'hA,4'h0,4'h0, 0,0,0,0,0, 1,0,2'd1,0,4'hF);
    add(4'hA,4'h0,4'h0, 1,0,0,0,0, 1,1,2'd1,1,4'hD);
    add(4'hA,4'h0,4'h0, 1,0,0,0,0, 1,1,2'd1,0,4'hD);
    add(4'hA,4'h0,4'h0, 1,1,0,0,0, 0,0,2'd1,0,4'hF);
    add(4'h0,4'h0,4'h0, 0,0,0,0,0, 1,0,2'd1,0,4'hF);
    add(4'h0,4'h0,4'h0, 0,0,0,0,0, 1,0,2'd1,0,4'hF);
    add(4'h0,4'h0,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h2,4'h2,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h2,4'h2,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h2,4'h2,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h2,4'h2,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h2,4'h2,4'h2, 0,0,0,0,0, 1,0,2'd1,0,4'hF);
    add(4'h2,4'h2,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h0,4'h2,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h0,4'h2,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h0,4'h0,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'hE,4'h0,4'h0, 0,0,1,1,0, 0,0,2'd0,0,4'h0);
    add(4'hE,4'h0,4'h0, 0,0,1,1,0, 0,0,2'd0,0,4'h0);
    add(4'hE,4'h0,4'h0, 0,0,1,1,0, 1,0,2'd0,0,4'h0);
    add(4'hE,4'h0,4'h0, 1,0,1,1,0, 1,1,2'd0,1,4'h1);
    add(4'hE,4'h0,4'h0, 1,1,1,1,0, 0,0,2'd0,0,4'h0);
    add(4'hF,4'h0,4'h0, 0,0,1,1,0, 1,0,2'd0,0,4'h0);
    add(4'hF,4'h0,4'h0, 0,0,1,1,0, 1,0,2'd0,0,4'h0);
    add(4'h0,4'h0,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h0,4'h0,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h1,4'h0,4'h0, 0,0,0,0,1, 0,0,2'd0,0,4'hF);
    add(4'h1,4'h0,4'h0, 0,0,0,0,1, 0,0,2'd0,0,4'hF);
    add(4'h1,4'h0,4'h0, 0,0,0,0,1, 0,0,2'd0,0,4'hF);
    add(4'h1,4'h0,4'h0, 0,0,0,0,0, 1,0,2'd0,0,4'hF);
    add(4'h1,4'h0,4'h0, 1,0,0,0,1, 1,1,2'd0,1,4'hE);
    add(4'h1,4'h0,4'h0, 1,0,0,0,1, 1,1,2'd0,0,4'hE);
    add(4'h0,4'h0,4'h0, 1,1,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h0,4'h0,4'h0, 0,0,0,0,0, 1,0,2'd0,0,4'hF);
    add(4'h0,4'h0,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);
    add(4'h0,4'h0,4'h0, 0,0,0,0,0, 0,0,2'd0,0,4'hF);

    // Clock/reset
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hrq", {3'b0, hrq}, 4'd0);
    chk("rst_dack", dack, 4'hF);
    chk("rst_state", {2'b0, fsm_state}, 4'd0);
    reset_n = 1'b1;
    chk("rst_gv", {3'b0, grant_valid}, 4'd0);
    chk("rst_gc", {2'b0, grant_ch}, 4'd0);
    chk("rst_svc", {3'b0, svc_start}, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      dreq = vecs[i].dreq; mask = vecs[i].mask; sw_req = vecs[i].sw_req;
      hlda = vecs[i].hlda; xfer_done = vecs[i].xfer_done;
      dreq_sense_low = vecs[i].dsl; dack_sense_high = vecs[i].dsh; ctrl_disable = vecs[i].dis;
      tick();
      chk($sformatf("v%0d_hrq", i), {3'b0, hrq}, {3'b0, vecs[i].e_hrq});
      chk($sformatf("v%0d_gv", i), {3'b0, grant_valid}, {3'b0, vecs[i].e_gv});
      chk($sformatf("v%0d_svc", i), {3'b0, svc_start}, {3'b0, vecs[i].e_svc});
      chk($sformatf("v%0d_dack", i), dack, vecs[i].e_dack);
      if (vecs[i].e_hrq) chk($sformatf("v%0d_gc", i), {2'b0, grant_ch}, {2'b0, vecs[i].e_gc});
    end
    hlda = 1'b0; xfer_done = 1'b0; ctrl_disable = 1'b0;

    // Rotating priority with all channels requesting
    rotating_pri = 1'b1;
    dreq = 4'hF;
    begin
      int n;
      n = 0;
      while (!hrq && n < 8) begin
        tick();
        n++;
      end
      chk("rot_first_latency", 4'(n), 4'd3);
    end
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    while (exp_q.size() > 0) do_service(exp_q.pop_front());

    // Aborted service on ch2 keeps the pointer at 2
    chk("abort_gc_pre", {2'b0, grant_ch}, 4'd2);
    hlda = 1'b1;
    tick();
    chk("abort_state_svc", {2'b0, fsm_state}, 4'd2);
    chk("abort_dack_svc", dack, 4'b1011);
    hlda = 1'b0;
    tick();
    chk("abort_dack", dack, 4'hF);
    chk("abort_hrq", {3'b0, hrq}, 4'd0);
    chk("abort_gv", {3'b0, grant_valid}, 4'd0);
    chk("abort_state", {2'b0, fsm_state}, 4'd0);
    tick();
    chk("abort_next_hrq", {3'b0, hrq}, 4'd1);
    chk("abort_next_gc", {2'b0, grant_ch}, 4'd2);

    // Asynchronous reset in the middle of a service
    hlda = 1'b1;
    tick();
    chk("midrst_pre_gv", {3'b0, grant_valid}, 4'd1);
    reset_n = 1'b0;
    hlda = 1'b0;
    #1;
    chk("midrst_hrq", {3'b0, hrq}, 4'd0);
    chk("midrst_gv", {3'b0, grant_valid}, 4'd0);
    chk("midrst_dack", dack, 4'hF);
    chk("midrst_state", {2'b0, fsm_state}, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk("postrst_e1_hrq", {3'b0, hrq}, 4'd0);
    tick();
    chk("postrst_e2_hrq", {3'b0, hrq}, 4'd0);
    tick();
    chk("postrst_e3_hrq", {3'b0, hrq}, 4'd1);
    chk("postrst_ptr_gc", {2'b0, grant_ch}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
